// File: rtl/snake_dir_queue.sv
// Snake direction command queue: detects new HID key presses, filters same-axis moves
// and applies queued directions on each frame tick. Optional macro: SNAKE_ARROW_KEYS_EN.
module snake_dir_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [15:0]              keycode,
  input  logic                     frame_clk,
  input  logic                     flush,
  output logic [1:0]               dir,
  output logic                     moving,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  function automatic logic key_ok(input logic [7:0] c);
    case (c)
      8'h1A, 8'h16, 8'h04, 8'h07: key_ok = 1'b1;
`ifdef SNAKE_ARROW_KEYS_EN
      8'h52, 8'h51, 8'h50, 8'h4F: key_ok = 1'b1;
`endif
      default:                    key_ok = 1'b0;
    endcase
  endfunction

  // Encoding: 00 up, 01 down, 10 left, 11 right.
  function automatic logic [1:0] key_dir(input logic [7:0] c);
    case (c)
      8'h1A:   key_dir = 2'b00;
      8'h16:   key_dir = 2'b01;
      8'h04:   key_dir = 2'b10;
`ifdef SNAKE_ARROW_KEYS_EN
      8'h52:   key_dir = 2'b00;
      8'h51:   key_dir = 2'b01;
      8'h50:   key_dir = 2'b10;
`endif
      default: key_dir = 2'b11;
    endcase
  endfunction

  logic [15:0]   key_q, key_prev;
  logic          new0, new1;
  logic          push_v;
  logic [1:0]    push_dir;
  logic          fs1, fs2, fs3;
  logic [2:0]    vld;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [1:0]    ref_dir;
  logic          tick, do_pop, push_ok, do_push, do_drop;

  always_comb begin
    new0 = key_ok(key_q[7:0]) && (key_q[7:0] != key_prev[7:0])
           && (key_q[7:0] != key_prev[15:8]);
    new1 = key_ok(key_q[15:8]) && (key_q[15:8] != key_prev[7:0])
           && (key_q[15:8] != key_prev[15:8]);
  end

  // vld tracks how many sync stages hold real samples, so no tick fires from reset values.
  always_comb begin
    tick    = fs2 & ~fs3 & vld[2];
    ref_dir = (count == '0) ? dir : mem[wr_ptr - PW'(1)];
    do_pop  = tick && (count != '0) && !flush;
    // Same bit 1 means same axis: equal or reverse direction.
    push_ok = push_v && (push_dir[1] != ref_dir[1]) && !flush;
    do_push = push_ok && ((count != FULL) || do_pop);
    do_drop = push_ok && (count == FULL) && !do_pop;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q    <= '0;
      key_prev <= '0;
      push_v   <= 1'b0;
      push_dir <= 2'b00;
      fs1      <= 1'b0;
      fs2      <= 1'b0;
      fs3      <= 1'b0;
      vld      <= '0;
    end else begin
      key_q    <= keycode;
      key_prev <= key_q;
      push_v   <= new0 | new1;
      push_dir <= new0 ? key_dir(key_q[7:0]) : key_dir(key_q[15:8]);
      fs1      <= frame_clk;
      fs2      <= fs1;
      fs3      <= fs2;
      vld      <= {vld[1:0], 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir    <= INIT_DIR;
      moving <= 1'b0;
      count  <= '0;
      drop   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      moving <= 1'b0;
      count  <= '0;
      drop   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      drop <= do_drop;
      if (do_pop) begin
        dir    <= mem[rd_ptr];
        moving <= 1'b1;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push)
      mem[wr_ptr] <= push_dir;
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed self-checking bench for snake_dir_queue (DEPTH=4, INIT_DIR=right).
module tb_snake_dir_queue;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] keycode = '0;
  logic        frame_clk = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  dir;
  logic        moving;
  logic [2:0]  count;
  logic        drop;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  int d0;

  snake_dir_queue #(.DEPTH(4), .INIT_DIR(2'b11)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
    .flush(flush), .dir(dir), .moving(moving), .count(count), .drop(drop)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk) if (drop === 1'b1) drop_cnt++;

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [15:0] k);
    keycode = k;
    step(4);
    keycode = '0;
    step(2);
  endtask

  task automatic frame_tick();
    frame_clk = 1'b1;
    step(4);
    frame_clk = 1'b0;
    step(3);
  endtask

  initial begin
    step(3);
    chk("rst_dir", 8'(dir), 8'h3);
    chk("rst_moving", 8'(moving), 8'h0);
    chk("rst_count", 8'(count), 8'h0);
    chk("rst_drop", 8'(drop), 8'h0);
    Reset_n = 1'b1;
    step(2);

    // Up press, then a tick applies it.
    press(16'h001A);
    chk("up_count", 8'(count), 8'h1);
    frame_tick();
    chk("tick_dir", 8'(dir), 8'h0);
    chk("tick_moving", 8'(moving), 8'h1);
    chk("tick_count", 8'(count), 8'h0);

    // Back to right, then reversal is rejected and a perpendicular press accepted.
    press(16'h0007);
    frame_tick();
    chk("right_dir", 8'(dir), 8'h3);
    press(16'h0004);
    chk("reverse_rej", 8'(count), 8'h0);
    press(16'h0016);
    chk("down_acc", 8'(count), 8'h1);

    // Arrow codes only count when the option is built in.
    flush = 1'b1; step(1); flush = 1'b0; step(1);
    chk("flush_count", 8'(count), 8'h0);
    chk("flush_moving", 8'(moving), 8'h0);
    chk("flush_dir", 8'(dir), 8'h3);
    press(16'h0052);
`ifdef SNAKE_ARROW_KEYS_EN
    chk("arrow_key", 8'(count), 8'h1);
`else
    chk("arrow_key", 8'(count), 8'h0);
`endif
    flush = 1'b1; step(1); flush = 1'b0; step(1);

    // Fill the queue and overflow once.
    d0 = drop_cnt;
    press(16'h001A);
    press(16'h0004);
    press(16'h0016);
    press(16'h0007);
    chk("full_count", 8'(count), 8'h4);
    chk("full_nodrop", 8'(drop_cnt - d0), 8'h0);
    press(16'h001A);
    chk("ovf_count", 8'(count), 8'h4);
    chk("ovf_drop", 8'(drop_cnt - d0), 8'h1);

    // Push and pop landing on the same cycle while full.
    d0 = drop_cnt;
    keycode = 16'h0016;
    frame_clk = 1'b1;
    step(4);
    keycode = '0;
    frame_clk = 1'b0;
    step(3);
    chk("pp_count", 8'(count), 8'h4);
    chk("pp_drop", 8'(drop_cnt - d0), 8'h0);
    chk("pp_dir", 8'(dir), 8'h0);

    // Queue left,down,right,down: one pop, then flush coinciding with the next pop.
    frame_tick();
    chk("pop_dir", 8'(dir), 8'h2);
    chk("pop_count", 8'(count), 8'h3);
    frame_clk = 1'b1;
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    frame_clk = 1'b0;
    step(3);
    chk("ft_count", 8'(count), 8'h0);
    chk("ft_moving", 8'(moving), 8'h0);
    chk("ft_dir", 8'(dir), 8'h2);

    // Two new presses at once: slot [7:0] wins, held key pushes once.
    press(16'h001A);
    frame_tick();
    chk("up2_dir", 8'(dir), 8'h0);
    keycode = 16'h1A07;
    step(100);
    chk("dual_count", 8'(count), 8'h1);
    keycode = '0;
    step(2);
    frame_tick();
    chk("dual_dir", 8'(dir), 8'h3);

    // Key and frame_clk both held high through reset release.
    Reset_n = 1'b0;
    keycode = 16'h0016;
    frame_clk = 1'b1;
    step(2);
    chk("rst2_dir", 8'(dir), 8'h3);
    Reset_n = 1'b1;
    step(5);
    chk("held_push", 8'(count), 8'h1);
    step(5);
    chk("no_false_tick", 8'(dir), 8'h3);
    chk("no_false_mov", 8'(moving), 8'h0);
    keycode = '0;
    frame_clk = 1'b0;
    step(4);
    frame_tick();
    chk("fresh_tick_dir", 8'(dir), 8'h1);
    chk("fresh_tick_mov", 8'(moving), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_dir_queue.md
SNAKE_DIR_QUEUE -- requirements
Module: snake_dir_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter INIT_DIR, default 2'b11, meaning the direction held after reset (right).
REQ-003 SHALL have port Clk, input, 1, meaning the 50 MHz system clock; all state is on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, meaning reset; it is asynchronous and active-low.
REQ-005 SHALL have port keycode, input, 16, meaning two USB HID key slots, [7:0] and [15:8], from the SoC PIO.
REQ-006 SHALL have port frame_clk, input, 1, meaning VGA vertical sync (asynchronous to Clk).
REQ-007 SHALL have port flush, input, 1, meaning synchronous queue clear (driven by endGame).
REQ-008 SHALL have port dir, output, 2, meaning the applied direction: 00 up, 01 down, 10 left, 11 right.
REQ-009 SHALL have port moving, output, 1, meaning at least one command has been applied since reset or flush.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1, meaning queued-entry count.
REQ-011 SHALL have port drop, output, 1, meaning a one-cycle pulse when an accepted press is discarded because the queue is full.

Function
REQ-012 SHALL map HID codes 0x1A to up, 0x16 to down, 0x04 to left and 0x07 to right; every other code SHALL be ignored.
REQ-013 SHALL register keycode each cycle; a slot is a new press when its code is non-zero, mapped, and absent from both slots of the previous sample.
REQ-014 SHALL, when both slots hold new presses in the same cycle, process slot [7:0] only and ignore slot [15:8].
REQ-015 SHALL reject a new press whose direction equals, or is the reverse of, the reference direction; the reference is the newest queued entry, or dir when the queue is empty.
REQ-016 SHALL push a non-rejected press onto the queue tail in the cycle after detection.
REQ-017 SHALL synchronise frame_clk through two flops; a 0-to-1 transition of the synchronised signal is a frame tick.
REQ-018 SHALL, on a frame tick with count>0, pop the head into dir and set moving; on a frame tick with count=0, dir SHALL be held.
REQ-019 SHALL, on a push with count=DEPTH and no same-cycle pop, discard the press, leave the queue unchanged and assert drop for one cycle.
REQ-020 SHALL, on a simultaneous push and pop, accept both, including when full; count is unchanged.
REQ-021 SHALL evaluate reversal against the pre-pop reference during a simultaneous push and pop.
REQ-022 SHALL, on flush, clear count and pointers and clear moving in that cycle, hold dir, and suppress any same-cycle push, pop or drop.
REQ-023 SHALL wrap pointers modulo DEPTH.
REQ-024 SHALL use no combinational path from keycode or frame_clk to any output.

Reset
REQ-025 SHALL, while Reset_n=0, force dir=INIT_DIR, moving=0, count=0, drop=0, pointers=0, the keycode sample register=0 and the sync flops=0.
REQ-026 SHALL, after reset release, detect no frame tick until a fresh 0-to-1 transition of frame_clk is seen.
REQ-027 SHALL treat a key held through reset release as a new press on the first cycle after release.

Configuration
REQ-028 SHALL, with macro SNAKE_ARROW_KEYS_EN defined, additionally map 0x52 to up, 0x51 to down, 0x50 to left and 0x4F to right with identical rules.
REQ-029 SHALL, without SNAKE_ARROW_KEYS_EN, ignore codes 0x4F to 0x52.

Verification
REQ-030 SHALL cover: reset, then keycode=0x001A, then one frame tick -> dir=00, moving=1, count=0.
REQ-031 SHALL cover: dir=11 and queue empty, then keycode=0x0004 -> no push, count=0; then 0x0016 -> count=1.
REQ-032 SHALL cover: DEPTH=4, four distinct alternating presses (up, left, down, right) with no tick, then a fifth press (up) -> count=4 and drop pulses once.
REQ-033 SHALL cover: full queue, then push and frame tick in the same cycle -> count stays 4, drop=0, and the head is applied to dir.
REQ-034 SHALL cover: keycode=0x1A07 arriving in one cycle -> only right is processed; 0x1A07 held for 100 cycles -> exactly one push.
REQ-035 SHALL cover: count=3 and flush asserted on a frame-tick cycle -> count=0, moving=0, dir unchanged.
